// File: rtl/ifu_fch_rsp_mem.sv
// Fetch-side responder: serves fetch requests from a local synchronous instruction memory
// through a 2-entry response FIFO, with flush, optional read wait states and a preload port.
module ifu_fch_rsp_mem #(
    parameter int unsigned        PC_SIZE     = 32,
    parameter int unsigned        IR_SIZE     = 32,
    parameter int unsigned        MEM_DEPTH   = 1024,
    parameter logic [PC_SIZE-1:0] PC_BASE     = '0,
    parameter int unsigned        WAIT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fch_req_vld,
    output logic                         fch_req_rdy,
    input  logic [PC_SIZE-1:0]           fch_req_pc,
    output logic                         fch_rsp_vld,
    input  logic                         fch_rsp_rdy,
    output logic [IR_SIZE-1:0]           fch_rsp_ir,
    output logic                         fch_rsp_err,
    input  logic                         fl_vld,
    input  logic                         ld_vld,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
    input  logic [IR_SIZE-1:0]           ld_data
);

    localparam int unsigned        AW    = $clog2(MEM_DEPTH);
    localparam logic [PC_SIZE:0]   PC_LO = {1'b0, PC_BASE};
    localparam logic [PC_SIZE:0]   PC_HI = PC_LO + (PC_SIZE + 1)'(4 * MEM_DEPTH);
    localparam logic [IR_SIZE-1:0] NOP   = IR_SIZE'(32'h0000_0013);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e             state_q;
    logic [3:0]         wait_cnt_q;
    logic [AW-1:0]      pend_idx_q;
    logic               pend_err_q;
    logic               rd_vld_q;
    logic               rd_err_q;
    logic [IR_SIZE-1:0] rd_data_q;
    logic [IR_SIZE-1:0] mem [MEM_DEPTH];

    logic [IR_SIZE-1:0] fifo_ir_q [2];
    logic [1:0]         fifo_err_q;
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         fifo_cnt_q;

    logic [PC_SIZE:0]   pc_ext;
    logic [PC_SIZE-1:0] pc_off;
    logic [AW-1:0]      req_idx;
    logic               req_err;
    logic               req_hsk;
    logic               rsp_hsk;
    logic [2:0]         occ;
    logic               room;
    logic               rd_go;
    logic [AW-1:0]      rd_idx;
    logic               rd_err;
    logic               push;
    logic               pop;

    // Range check is done one bit wider so the top of the window cannot wrap.
    assign pc_ext  = {1'b0, fch_req_pc};
    assign pc_off  = fch_req_pc - PC_BASE;
    assign req_idx = AW'(pc_off >> 2);
    assign req_err = (fch_req_pc[1:0] != 2'b00) | (pc_ext < PC_LO) | (pc_ext >= PC_HI);

    assign fch_rsp_vld = (fifo_cnt_q != 2'd0);
    assign fch_rsp_ir  = fch_rsp_vld ? fifo_ir_q[rd_ptr_q] : '0;
    assign fch_rsp_err = fch_rsp_vld & fifo_err_q[rd_ptr_q];

    assign rsp_hsk = fch_rsp_vld & fch_rsp_rdy;
    assign push    = rd_vld_q;
    assign pop     = rsp_hsk;

    // Slots already claimed (buffered + in flight) minus the one leaving this cycle.
    assign occ  = {1'b0, fifo_cnt_q} + {2'b00, rd_vld_q};
    assign room = occ < (3'd2 + {2'b00, rsp_hsk});

    assign fch_req_rdy = ~rst & ~fl_vld & (state_q == StIdle) & room;
    assign req_hsk     = fch_req_vld & fch_req_rdy;

    always_comb begin
        rd_go  = 1'b0;
        rd_idx = req_idx;
        rd_err = req_err;
        if (WAIT_CYCLES == 0) begin
            rd_go = req_hsk;
        end else begin
            rd_go  = (state_q == StWait) && (wait_cnt_q == 4'd1);
            rd_idx = pend_idx_q;
            rd_err = pend_err_q;
        end
    end

    // Memory is never reset; read-before-write falls out of non-blocking semantics.
    always_ff @(posedge clk) begin
        if (ld_vld) begin
            mem[ld_addr] <= ld_data;
        end
        if (rd_go) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fl_vld) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            rd_vld_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            rd_vld_q <= rd_go;
            case (state_q)
                StIdle: begin
                    if (req_hsk && (WAIT_CYCLES != 0)) begin
                        state_q    <= StWait;
                        wait_cnt_q <= 4'(WAIT_CYCLES);
                    end
                end
                StWait: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (req_hsk) begin
            pend_idx_q <= req_idx;
            pend_err_q <= req_err;
        end
        if (rd_go) begin
            rd_err_q <= rd_err;
        end
        if (push) begin
            fifo_ir_q[wr_ptr_q]  <= rd_err_q ? NOP : rd_data_q;
            fifo_err_q[wr_ptr_q] <= rd_err_q;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_cnt_q == 2'd2)));
    assert property (@(posedge clk) disable iff (rst)
        !(pop && (fifo_cnt_q == 2'd0)));

endmodule

// File: tb/tb_ifu_fch_rsp_mem.sv
// Directed bench for ifu_fch_rsp_mem: one instance with no wait states, one with three.
module tb_ifu_fch_rsp_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld, req_rdy, rsp_vld, rsp_rdy, rsp_err;
    logic [31:0] req_pc, rsp_ir;
    logic        w_req_vld, w_req_rdy, w_rsp_vld, w_rsp_rdy, w_rsp_err;
    logic [31:0] w_req_pc, w_rsp_ir;
    logic        fl, ld_vld;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] B1 = 32'hB000_0001;

    always #5 clk = ~clk;

    ifu_fch_rsp_mem #(.WAIT_CYCLES(0)) dut (
        .clk(clk), .rst(rst),
        .fch_req_vld(req_vld), .fch_req_rdy(req_rdy), .fch_req_pc(req_pc),
        .fch_rsp_vld(rsp_vld), .fch_rsp_rdy(rsp_rdy), .fch_rsp_ir(rsp_ir),
        .fch_rsp_err(rsp_err), .fl_vld(fl),
        .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ifu_fch_rsp_mem #(.WAIT_CYCLES(3)) dut_w (
        .clk(clk), .rst(rst),
        .fch_req_vld(w_req_vld), .fch_req_rdy(w_req_rdy), .fch_req_pc(w_req_pc),
        .fch_rsp_vld(w_rsp_vld), .fch_rsp_rdy(w_rsp_rdy), .fch_rsp_ir(w_rsp_ir),
        .fch_rsp_err(w_rsp_err), .fl_vld(fl),
        .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    function automatic logic [31:0] a(input int i);
        return 32'hA000_0000 | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic [31:0] t3_pc  [5];
    logic [31:0] t3_ir  [5];
    logic        t3_err [5];
    int          nxt;
    logic        exp_rdy, exp_vld;

    initial begin
        rst = 1'b1; req_vld = 0; req_pc = '0; rsp_rdy = 0; fl = 0;
        w_req_vld = 0; w_req_pc = '0; w_rsp_rdy = 1'b1;
        ld_vld = 0; ld_addr = '0; ld_data = '0;
        t3_pc  = '{32'h0000_0FFC, 32'h0000_0002, 32'h0000_0000, 32'h0000_1000, 32'h0000_0004};
        t3_ir  = '{a(1023), 32'h13, a(0), 32'h13, a(1)};
        t3_err = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        next_cycle();
        sample();
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_ir", rsp_ir, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_w_rsp_vld", w_rsp_vld, 0);
        next_cycle();

        // Preload words 0..3 and the last word
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_vld  = 1'b1;
            ld_addr = (i == 4) ? 10'd1023 : 10'(i);
            ld_data = (i == 4) ? a(1023) : a(i);
            sample();
            if (i == 0) chk("idle_req_rdy", req_rdy, 1);
            next_cycle();
        end
        ld_vld = 1'b0;

        // Back-to-back fetches, no backpressure
        for (int c = 0; c < 8; c++) begin
            req_vld = (c < 4); req_pc = 32'(4 * c); rsp_rdy = 1'b1;
            sample();
            if (c < 4) chk("t1_req_rdy", req_rdy, 1);
            chk("t1_rsp_vld", rsp_vld, (c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) begin
                chk("t1_rsp_ir", rsp_ir, a(c - 2));
                chk("t1_rsp_err", rsp_err, 0);
            end
            next_cycle();
        end
        req_vld = 1'b0;

        // Backpressure: two slots fill, release at relative cycle 10
        nxt = 0;
        for (int c = 0; c < 15; c++) begin
            rsp_rdy = (c >= 10); req_vld = (c < 12); req_pc = 32'(4 * nxt);
            exp_rdy = (c < 2) || (c == 10) || (c == 11);
            exp_vld = (c >= 2) && (c <= 13);
            sample();
            if (c < 12) chk("t2_req_rdy", req_rdy, exp_rdy);
            chk("t2_rsp_vld", rsp_vld, exp_vld);
            if (exp_vld) chk("t2_rsp_ir", rsp_ir, (c <= 10) ? a(0) : a(c - 10));
            if (exp_rdy && c < 12) nxt++;
            next_cycle();
        end
        req_vld = 1'b0;

        // Error responses interleaved with good ones
        for (int c = 0; c < 7; c++) begin
            rsp_rdy = 1'b1; req_vld = (c < 5); req_pc = (c < 5) ? t3_pc[c] : 32'h0;
            sample();
            if (c < 5) chk("t3_req_rdy", req_rdy, 1);
            chk("t3_rsp_vld", rsp_vld, (c >= 2));
            if (c >= 2) begin
                chk("t3_rsp_ir", rsp_ir, t3_ir[c - 2]);
                chk("t3_rsp_err", rsp_err, t3_err[c - 2]);
            end
            next_cycle();
        end
        req_vld = 1'b0;

        // Three wait states on the second instance
        for (int c = 0; c < 7; c++) begin
            w_req_vld = (c == 0); w_req_pc = 32'h8;
            sample();
            chk("t4_req_rdy", w_req_rdy, (c == 0) || (c >= 4));
            chk("t4_rsp_vld", w_rsp_vld, (c == 5));
            if (c == 5) begin
                chk("t4_rsp_ir", w_rsp_ir, a(2));
                chk("t4_rsp_err", w_rsp_err, 0);
            end
            next_cycle();
        end
        w_req_vld = 1'b0;

        // Flush at relative cycle 2 with one buffered and one in flight
        for (int c = 0; c < 7; c++) begin
            rsp_rdy = (c >= 3); fl = (c == 2); req_vld = (c <= 3);
            req_pc  = (c == 0) ? 32'h0 : (c == 1) ? 32'h4 : 32'h8;
            sample();
            if (c <= 3) chk("t5_req_rdy", req_rdy, (c != 2));
            chk("t5_rsp_vld", rsp_vld, (c == 2) || (c == 5));
            if (c == 2) chk("t5_rsp_ir_pre", rsp_ir, a(0));
            if (c == 5) chk("t5_rsp_ir_post", rsp_ir, a(2));
            next_cycle();
        end
        fl = 1'b0; req_vld = 1'b0;

        // Load collision, then reset mid-stream
        for (int c = 0; c < 11; c++) begin
            rsp_rdy = 1'b1; req_pc = 32'h4;
            req_vld = (c == 0) || (c == 3) || (c == 6) || (c == 8);
            ld_vld  = (c == 0); ld_addr = 10'd1; ld_data = B1;
            rst     = (c == 7);
            sample();
            if (c == 7) chk("t6_req_rdy_rst", req_rdy, 0);
            if (c == 8) chk("t6_req_rdy_after", req_rdy, 1);
            chk("t6_rsp_vld", rsp_vld, (c == 2) || (c == 5) || (c == 10));
            if (c == 2) chk("t6_rsp_ir_old", rsp_ir, a(1));
            if (c == 5 || c == 10) chk("t6_rsp_ir_new", rsp_ir, B1);
            next_cycle();
        end
        req_vld = 1'b0; ld_vld = 1'b0; rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
